wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 57 +++++
 rtl/wb_stage_if.sv | 42 ++++
 rtl/wb_stage_ld_queue.sv | 51 +++++
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types, codes and load-formatting helper for the writeback stage.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned LDQ_DEPTH  = 4;
  localparam int unsigned LDQ_PTR_W  = 2;
  localparam int unsigned LDQ_CNT_W  = 3;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_8    = 2'b01;
  localparam logic [1:0] WB_16   = 2'b10;
  localparam logic [1:0] WB_32   = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        off;
  } ldq_entry_t;

  typedef struct packed {
    logic [1:0]      we;
    logic [XLEN-1:0] data;
  } wb_write_t;

  // Align the raw word by the byte offset, then extend to the requested width.
  function automatic wb_write_t ld_format(input logic [XLEN-1:0] raw, input ldq_entry_t e);
    logic [XLEN-1:0] sh;
    sh = raw >> {e.off, 3'b000};
    ld_format.we   = WB_32;
    ld_format.data = sh;
    case (e.size)
      SZ_BYTE: begin
        if (e.sgn) ld_format.data = {{24{sh[7]}}, sh[7:0]};
        else begin
          ld_format.we   = WB_8;
          ld_format.data = {24'b0, sh[7:0]};
        end
      end
      SZ_HALF: begin
        if (e.sgn) ld_format.data = {{16{sh[15]}}, sh[15:0]};
        else begin
          ld_format.we   = WB_16;
          ld_format.data = {16'b0, sh[15:0]};
        end
      end
      default: ld_format.data = sh;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Handshake and register-file signals of the writeback stage.
interface wb_stage_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              ld_issue_valid;
  logic              ld_issue_ready;
  logic [REG_AW-1:0] ld_issue_rd;
  logic [1:0]        ld_issue_size;
  logic              ld_issue_signed;
  logic [1:0]        ld_issue_off;

  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;

  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              hazard;

  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [1:0]        wb_we;
  logic              rsp_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd, ld_issue_size, ld_issue_signed, ld_issue_off,
    output mem_rsp_valid, mem_rsp_data, rs1_addr, rs2_addr,
    input  alu_ready, ld_issue_ready, hazard, wb_addr, wb_data, wb_we, rsp_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd, ld_issue_size, ld_issue_signed, ld_issue_off,
    input  mem_rsp_valid, mem_rsp_data, rs1_addr, rs2_addr,
    output alu_ready, ld_issue_ready, hazard, wb_addr, wb_data, wb_we, rsp_err
  );
endinterface

// File: rtl/wb_stage_ld_queue.sv
// In-order FIFO of outstanding load metadata with occupancy count.
module ld_queue
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  ldq_entry_t           din,
  input  logic                 pop,
  output ldq_entry_t           head,
  output logic [LDQ_CNT_W-1:0] count,
  output logic                 full,
  output logic                 empty
);

  ldq_entry_t           r_mem [LDQ_DEPTH];
  logic [LDQ_PTR_W-1:0] r_wr_ptr;
  logic [LDQ_PTR_W-1:0] r_rd_ptr;
  logic [LDQ_CNT_W-1:0] r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full   = (r_count == LDQ_CNT_W'(LDQ_DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers are exactly log2(depth) wide, so they wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LDQ_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LDQ_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LDQ_CNT_W'(1);
        2'b01:   r_count <= r_count - LDQ_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load responses over ALU results, formats loads, tracks load hazards.
module wb_stage
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  ldq_entry_t           w_head;
  ldq_entry_t           w_din;
  logic [LDQ_CNT_W-1:0] w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_alu_fire;
  wb_write_t            w_ld;

  logic [REG_AW-1:0]    w_wb_addr;
  logic [XLEN-1:0]      w_wb_data;
  logic [1:0]           w_wb_we;
  logic [NUM_REGS-1:0]  w_busy;

  logic [REG_AW-1:0]    r_wb_addr;
  logic [XLEN-1:0]      r_wb_data;
  logic [1:0]           r_wb_we;
  logic [NUM_REGS-1:0]  r_busy;
  logic                 r_rsp_err;

  // Readiness depends only on registered state; a same-cycle pop frees nothing.
  assign bus.ld_issue_ready = (w_count < LDQ_CNT_W'(LDQ_DEPTH)) && !r_busy[bus.ld_issue_rd];
  assign bus.alu_ready      = !(rst && bus.mem_rsp_valid);
  assign bus.hazard         = r_busy[bus.rs1_addr] | r_busy[bus.rs2_addr];
  assign bus.wb_addr        = r_wb_addr;
  assign bus.wb_data        = r_wb_data;
  assign bus.wb_we          = r_wb_we;
  assign bus.rsp_err        = r_rsp_err;

  assign w_push     = bus.ld_issue_valid && bus.ld_issue_ready;
  assign w_pop      = bus.mem_rsp_valid && !w_empty;
  assign w_alu_fire = bus.alu_valid && bus.alu_ready;
  assign w_din      = '{rd: bus.ld_issue_rd, size: bus.ld_issue_size,
                        sgn: bus.ld_issue_signed, off: bus.ld_issue_off};
  assign w_ld       = ld_format(bus.mem_rsp_data, w_head);

  ld_queue u_ld_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_wb_addr = '0;
    w_wb_data = '0;
    w_wb_we   = WB_NONE;
    if (w_pop) begin
      if (w_head.rd != '0) begin
        w_wb_addr = w_head.rd;
        w_wb_data = w_ld.data;
        w_wb_we   = w_ld.we;
      end
    end else if (w_alu_fire && (bus.alu_rd != '0)) begin
      w_wb_addr = bus.alu_rd;
      w_wb_data = bus.alu_data;
      w_wb_we   = WB_32;
    end
  end

  // Clear-before-set is safe: an issue to a busy register is never accepted.
  always_comb begin
    w_busy = r_busy;
    if (w_pop)  w_busy[w_head.rd]     = 1'b0;
    if (w_push) w_busy[bus.ld_issue_rd] = 1'b1;
    w_busy[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_we   <= WB_NONE;
      r_busy    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_wb_addr <= w_wb_addr;
      r_wb_data <= w_wb_data;
      r_wb_we   <= w_wb_we;
      r_busy    <= w_busy;
      if (bus.mem_rsp_valid && w_empty) r_rsp_err <= 1'b1;
    end
  end

  a_full_matches_count: assert property (@(posedge clk) disable iff (!rst)
    w_full == (w_count == LDQ_CNT_W'(LDQ_DEPTH)));

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run against a queue model.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_stage_if bus();

  wb_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rd;
    int size;
    int sgn;
    int off;
  } ld_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_issue_valid = 0; bus.ld_issue_rd = '0; bus.ld_issue_size = SZ_WORD;
    bus.ld_issue_signed = 0; bus.ld_issue_off = '0;
    bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  task automatic issue(input int rd, input logic [1:0] size, input logic sgn, input int off);
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'(rd); bus.ld_issue_size = size;
    bus.ld_issue_signed = sgn; bus.ld_issue_off = 2'(off);
  endtask

  // Reference load formatting from the byte-lane arithmetic of a load.
  function automatic void model_load(input ld_t e, input logic [31:0] raw,
                                     output int we, output logic [31:0] val);
    logic [31:0] sh;
    int unsigned field;
    sh = raw >> (8 * e.off);
    if (e.size == 0) begin
      field = sh % 256;
      val = (e.sgn != 0 && field >= 128) ? 32'(field) - 32'd256 : 32'(field);
      we = (e.sgn != 0) ? 3 : 1;
    end else if (e.size == 1) begin
      field = sh % 65536;
      val = (e.sgn != 0 && field >= 32768) ? 32'(field) - 32'd65536 : 32'(field);
      we = (e.sgn != 0) ? 3 : 2;
    end else begin
      val = sh;
      we = 3;
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    bus.mem_rsp_valid = 1;
    #1;
    checks++; if (bus.wb_we !== WB_NONE || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb: addr=%0d data=%h we=%0d want idle", bus.wb_addr, bus.wb_data, bus.wb_we); end
    checks++; if (bus.alu_ready !== 1'b1 || bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: alu=%b ld=%b want 1 1", bus.alu_ready, bus.ld_issue_ready); end
    checks++; if (bus.hazard !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags: hazard=%b err=%b want 0 0", bus.hazard, bus.rsp_err); end
    bus.mem_rsp_valid = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_signed_byte();
    issue(5, SZ_BYTE, 1, 2);
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b want 1", bus.ld_issue_ready); end
    tick();
    bus.ld_issue_valid = 0; bus.rs1_addr = 5'd5;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL sb_hazard_set: got %b want 1", bus.hazard); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h0080_1234;
    tick();
    bus.mem_rsp_valid = 0;
    checks++; if (bus.wb_addr !== 5'd5 || bus.wb_we !== WB_32 || bus.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sb_write: addr=%0d we=%0d data=%h want 5 3 ffffff80", bus.wb_addr, bus.wb_we, bus.wb_data); end
    #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL sb_hazard_clr: got %b want 0", bus.hazard); end
    tick();
    checks++; if (bus.wb_we !== WB_NONE || bus.wb_addr !== 5'd0) begin errors++; $display("FAIL sb_idle_after: addr=%0d we=%0d want 0 0", bus.wb_addr, bus.wb_we); end
    idle_inputs();
  endtask

  task automatic test_priority();
    issue(9, SZ_HALF, 0, 0);
    tick();
    bus.ld_issue_valid = 0;
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hABCD_8765;
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1111_1111;
    #1;
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL pri_alu_ready: got %b want 0", bus.alu_ready); end
    tick();
    bus.mem_rsp_valid = 0;
    checks++; if (bus.wb_addr !== 5'd9 || bus.wb_we !== WB_16 || bus.wb_data !== 32'h0000_8765) begin errors++; $display("FAIL pri_load_first: addr=%0d we=%0d data=%h want 9 2 00008765", bus.wb_addr, bus.wb_we, bus.wb_data); end
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL pri_alu_ready_back: got %b want 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 0;
    checks++; if (bus.wb_addr !== 5'd3 || bus.wb_we !== WB_32 || bus.wb_data !== 32'h1111_1111) begin errors++; $display("FAIL pri_alu_second: addr=%0d we=%0d data=%h want 3 3 11111111", bus.wb_addr, bus.wb_we, bus.wb_data); end
    idle_inputs();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      issue(i, SZ_WORD, 0, 0);
      #1;
      checks++; if (bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d: got %b want 1", i, bus.ld_issue_ready); end
      tick();
    end
    issue(6, SZ_WORD, 0, 0);
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b want 0", bus.ld_issue_ready); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1000_0001;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_free: got %b want 0", bus.ld_issue_ready); end
    tick();
    bus.ld_issue_valid = 0;
    checks++; if (bus.wb_addr !== 5'd1 || bus.wb_data !== 32'h1000_0001) begin errors++; $display("FAIL full_pop1: addr=%0d data=%h want 1 10000001", bus.wb_addr, bus.wb_data); end
    for (int i = 2; i <= 4; i++) begin
      bus.mem_rsp_data = 32'h1000_0000 + 32'(i);
      tick();
      checks++; if (bus.wb_addr !== 5'(i) || bus.wb_data !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL full_drain%0d: addr=%0d data=%h", i, bus.wb_addr, bus.wb_data); end
    end
    bus.mem_rsp_valid = 0; bus.rs1_addr = 5'd6; bus.rs2_addr = 5'd4;
    #1;
    checks++; if (bus.hazard !== 1'b0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL full_no_extra: hazard=%b err=%b want 0 0", bus.hazard, bus.rsp_err); end
    idle_inputs();
    tick();
  endtask

  task automatic test_busy();
    issue(7, SZ_BYTE, 0, 1);
    tick();
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL busy_block: got %b want 0", bus.ld_issue_ready); end
    tick();
    bus.rs1_addr = 5'd7;
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b0 || bus.hazard !== 1'b1) begin errors++; $display("FAIL busy_hold: ready=%b hazard=%b want 0 1", bus.ld_issue_ready, bus.hazard); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h0000_AB00;
    tick();
    bus.mem_rsp_valid = 0;
    checks++; if (bus.wb_addr !== 5'd7 || bus.wb_we !== WB_8 || bus.wb_data !== 32'h0000_00AB) begin errors++; $display("FAIL busy_write: addr=%0d we=%0d data=%h want 7 1 000000ab", bus.wb_addr, bus.wb_we, bus.wb_data); end
    #1;
    checks++; if (bus.ld_issue_ready !== 1'b1 || bus.hazard !== 1'b0) begin errors++; $display("FAIL busy_release: ready=%b hazard=%b want 1 0", bus.ld_issue_ready, bus.hazard); end
    tick();
    bus.ld_issue_valid = 0;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL busy_reissue: hazard=%b want 1", bus.hazard); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h1234_5678;
    tick();
    checks++; if (bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h0000_0056) begin errors++; $display("FAIL busy_second: addr=%0d data=%h want 7 00000056", bus.wb_addr, bus.wb_data); end
    idle_inputs();
    tick();
  endtask

  task automatic test_rsp_err_and_reset();
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", bus.rsp_err); end
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hDEAD_BEEF;
    bus.alu_valid = 1; bus.alu_rd = 5'd8; bus.alu_data = 32'h5555_5555;
    tick();
    idle_inputs();
    checks++; if (bus.rsp_err !== 1'b1 || bus.wb_we !== WB_NONE || bus.wb_addr !== 5'd0) begin errors++; $display("FAIL err_empty_rsp: err=%b addr=%0d we=%0d want 1 0 0", bus.rsp_err, bus.wb_addr, bus.wb_we); end
    issue(10, SZ_WORD, 0, 0); tick();
    issue(11, SZ_WORD, 0, 0); tick();
    bus.ld_issue_valid = 0; bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL err_pending_hazard: got %b want 1", bus.hazard); end
    rst = 0; bus.mem_rsp_valid = 1;
    #1;
    checks++; if (bus.hazard !== 1'b0 || bus.rsp_err !== 1'b0 || bus.wb_we !== WB_NONE) begin errors++; $display("FAIL midreset_clear: hazard=%b err=%b we=%0d want 0 0 0", bus.hazard, bus.rsp_err, bus.wb_we); end
    checks++; if (bus.alu_ready !== 1'b1 || bus.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: alu=%b ld=%b want 1 1", bus.alu_ready, bus.ld_issue_ready); end
    tick();
    rst = 1;
    tick();
    bus.mem_rsp_valid = 0;
    checks++; if (bus.rsp_err !== 1'b1 || bus.wb_we !== WB_NONE) begin errors++; $display("FAIL postreset_empty: err=%b we=%0d want 1 0", bus.rsp_err, bus.wb_we); end
    idle_inputs();
  endtask

  task automatic test_random();
    ld_t         q[$];
    ld_t         e;
    bit [31:0]   m_busy;
    bit          m_err;
    int          exp_addr, exp_we, rd;
    logic [31:0] exp_data, v;
    bit          exp_ld_ready, rsp;
    idle_inputs();
    rst = 0; tick(); rst = 1; tick();
    m_busy = '0; m_err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd = 5'($urandom_range(0, 7));
      bus.alu_data = $urandom;
      bus.ld_issue_valid = 1'($urandom_range(0, 1));
      bus.ld_issue_rd = 5'($urandom_range(0, 7));
      bus.ld_issue_size = 2'($urandom_range(0, 2));
      bus.ld_issue_signed = 1'($urandom_range(0, 1));
      bus.ld_issue_off = 2'($urandom_range(0, 3));
      rsp = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      bus.mem_rsp_valid = rsp;
      bus.mem_rsp_data = $urandom;
      bus.rs1_addr = 5'($urandom_range(0, 7));
      bus.rs2_addr = 5'($urandom_range(0, 7));
      #1;
      exp_ld_ready = (q.size() < 4) && !m_busy[bus.ld_issue_rd];
      checks++; if (bus.alu_ready !== !rsp) begin errors++; $display("FAIL rnd_alu_ready c%0d: got %b want %b", cyc, bus.alu_ready, !rsp); end
      checks++; if (bus.ld_issue_ready !== exp_ld_ready) begin errors++; $display("FAIL rnd_ld_ready c%0d: got %b want %b", cyc, bus.ld_issue_ready, exp_ld_ready); end
      checks++; if (bus.hazard !== (m_busy[bus.rs1_addr] | m_busy[bus.rs2_addr])) begin errors++; $display("FAIL rnd_hazard c%0d: got %b", cyc, bus.hazard); end
      exp_addr = 0; exp_data = '0; exp_we = 0;
      if (rsp && q.size() > 0) begin
        e = q.pop_front();
        if (e.rd != 0) begin
          model_load(e, bus.mem_rsp_data, exp_we, v);
          exp_addr = e.rd; exp_data = v;
          m_busy[e.rd] = 0;
        end
      end else if (rsp) begin
        m_err = 1;
      end else if (bus.alu_valid && bus.alu_rd != 0) begin
        exp_addr = int'(bus.alu_rd); exp_data = bus.alu_data; exp_we = 3;
      end
      if (bus.ld_issue_valid && exp_ld_ready) begin
        rd = int'(bus.ld_issue_rd);
        q.push_back('{rd: rd, size: int'(bus.ld_issue_size), sgn: int'(bus.ld_issue_signed), off: int'(bus.ld_issue_off)});
        if (rd != 0) m_busy[rd] = 1;
      end
      tick();
      checks++; if (bus.wb_addr !== 5'(exp_addr) || bus.wb_data !== exp_data || bus.wb_we !== 2'(exp_we)) begin errors++; $display("FAIL rnd_wb c%0d: addr=%0d data=%h we=%0d want %0d %h %0d", cyc, bus.wb_addr, bus.wb_data, bus.wb_we, exp_addr, exp_data, exp_we); end
      checks++; if (bus.rsp_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b want %b", cyc, bus.rsp_err, m_err); end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    idle_inputs();
    test_reset();
    test_signed_byte();
    test_priority();
    test_full();
    test_busy();
    test_rsp_err_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
